ram32x3_bist: RTL and testbench

Built-in self-test initiator for the 32-word × 3-bit synchronous RAM, which registers its inputs and has a read latency of one clock. On a `start` pulse the block takes over the RAM's `address`/`data`/`wren` port. It writes a known pattern to every word, reads each word back and compares it against the expected value, then reports pass/fail, an error count and the first failing address. It sits between the board-level control logic (switches/keys) and the RAM instance.

---
 rtl/ram32x3_bist_pkg.sv | 29 ++
 rtl/ram32x3_bist_expect_pipe.sv | 59 +++++
 rtl/ram32x3_bist.sv | 187 ++++++++++++++++++
 tb/tb_ram32x3_bist.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram32x3_bist_pkg.sv
// Shared types, constants and the test-pattern function for the
// 32x3 RAM built-in self-test initiator.
package ram32x3_bist_pkg;

    // Test sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    // Width of the saturating mismatch counter (saturates at 63)
    localparam int ERR_CNT_W = 6;

    // Default geometry of the RAM under test
    localparam int RAM_ADDR_W = 5;
    localparam int PAT_W      = 3;

    // Expected word for an address. Only the low PAT_W address bits shape
    // the pattern, so callers hand in that slice. Pass 0 writes the address
    // itself, pass 1 writes its complement so every cell sees both values.
    function automatic logic [PAT_W-1:0] bist_pattern(input logic [PAT_W-1:0] addr,
                                                      input logic             pass_idx);
        return pass_idx ? ~addr : addr;
    endfunction

endpackage

// File: rtl/ram32x3_bist_expect_pipe.sv
// Expected-value delay line for the BIST read path. Each read address and
// its expected word enter here on the edge that drives the address, and
// leave DEPTH edges later, exactly when the RAM word for that address is
// sampled.
module bist_expect_pipe #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_exp,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_exp
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic              v_in;
            logic [ADDR_W-1:0] a_in;
            logic [DATA_W-1:0] e_in;
            logic              v_reg;
            logic [ADDR_W-1:0] a_reg;
            logic [DATA_W-1:0] e_reg;

            if (gi == 0) begin : g_head
                assign v_in = in_valid;
                assign a_in = in_addr;
                assign e_in = in_exp;
            end else begin : g_link
                assign v_in = g_stage[gi-1].v_reg;
                assign a_in = g_stage[gi-1].a_reg;
                assign e_in = g_stage[gi-1].e_reg;
            end

            // One stage of the {valid, addr, expected} shift register
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    v_reg <= 1'b0;
                    a_reg <= '0;
                    e_reg <= '0;
                end else begin
                    v_reg <= v_in;
                    a_reg <= a_in;
                    e_reg <= e_in;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[DEPTH-1].v_reg;
    assign out_addr  = g_stage[DEPTH-1].a_reg;
    assign out_exp   = g_stage[DEPTH-1].e_reg;

endmodule

// File: rtl/ram32x3_bist.sv
// Built-in self-test initiator for the 32x3 synchronous RAM: writes a
// pattern to every word, reads it back through a RD_LAT-aligned expect
// pipeline and reports pass/fail, a saturating error count and the first
// failing address.
// Optional feature: define RAM32X3_BIST_INV_PASS_EN to add a second pass
// with the complemented pattern.
module ram32x3_bist
    import ram32x3_bist_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = PAT_W,
    parameter int RD_LAT = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]    first_fail_addr,
    output logic [ADDR_W-1:0]    address,
    output logic [DATA_W-1:0]    data,
    output logic                 wren,
    input  logic [DATA_W-1:0]    q
);

    localparam int DCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    bist_state_t       state_reg;
    logic [DCNT_W-1:0] drain_cnt_reg;
    logic [ADDR_W-1:0] addr_inc;
    logic              addr_last;
    logic              pass_cur;
    logic              more_passes;

    logic              push_valid;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_exp;
    logic [DATA_W-1:0] wr_next_data;
    logic              exp_valid;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

`ifdef RAM32X3_BIST_INV_PASS_EN
    logic pass_idx_reg;
    assign pass_cur    = pass_idx_reg;
    assign more_passes = ~pass_idx_reg;
`else
    assign pass_cur    = 1'b0;
    assign more_passes = 1'b0;
`endif

    assign addr_inc  = address + ADDR_W'(1);
    assign addr_last = (address == '1);

    // Next read address enters the expect pipe on the edge that loads it
    // into the address register: address 0 on the WRITE->READ edge, then
    // each increment inside READ.
    always_comb begin
        push_valid = 1'b0;
        push_addr  = addr_inc;
        if (state_reg == ST_WRITE && addr_last) begin
            push_valid = 1'b1;
            push_addr  = '0;
        end else if (state_reg == ST_READ && !addr_last) begin
            push_valid = 1'b1;
        end
        push_exp     = bist_pattern(push_addr[DATA_W-1:0], pass_cur);
        wr_next_data = bist_pattern(addr_inc[DATA_W-1:0], pass_cur);
    end

    bist_expect_pipe #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (RD_LAT)
    ) u_expect_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (push_valid),
        .in_addr   (push_addr),
        .in_exp    (push_exp),
        .out_valid (exp_valid),
        .out_addr  (exp_addr),
        .out_exp   (exp_data)
    );

    // Sequencer, compare/score logic and all registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            drain_cnt_reg   <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            address         <= '0;
            data            <= '0;
            wren            <= 1'b0;
`ifdef RAM32X3_BIST_INV_PASS_EN
            pass_idx_reg    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;

            // Score the word returning for the oldest outstanding read
            if (exp_valid && (q != exp_data)) begin
                if (err_count != '1) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
                if (err_count == '0) begin
                    first_fail_addr <= exp_addr;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    wren <= 1'b0;
                    if (start) begin
                        err_count       <= '0;
                        pass            <= 1'b0;
                        first_fail_addr <= '0;
`ifdef RAM32X3_BIST_INV_PASS_EN
                        pass_idx_reg    <= 1'b0;
`endif
                        address         <= '0;
                        data            <= bist_pattern('0, 1'b0);
                        wren            <= 1'b1;
                        busy            <= 1'b1;
                        state_reg       <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (addr_last) begin
                        address   <= '0;
                        wren      <= 1'b0;
                        state_reg <= ST_READ;
                    end else begin
                        address <= addr_inc;
                        data    <= wr_next_data;
                    end
                end

                ST_READ: begin
                    if (addr_last) begin
                        drain_cnt_reg <= '0;
                        state_reg     <= ST_DRAIN;
                    end else begin
                        address <= addr_inc;
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt_reg == DCNT_W'(RD_LAT - 1)) begin
                        if (more_passes) begin
`ifdef RAM32X3_BIST_INV_PASS_EN
                            pass_idx_reg <= 1'b1;
`endif
                            address   <= '0;
                            data      <= bist_pattern('0, 1'b1);
                            wren      <= 1'b1;
                            state_reg <= ST_WRITE;
                        end else begin
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_count == '0);
                            state_reg <= ST_DONE;
                        end
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + DCNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram32x3_bist.sv
// Self-checking bench for ram32x3_bist with a behavioural 32x3 RAM
// (registered inputs, one-clock read latency, write-through) and
// injectable read-path faults. Honours RAM32X3_BIST_INV_PASS_EN.
module tb_ram32x3_bist;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_count;
    logic [4:0] first_fail_addr;
    logic [4:0] address;
    logic [2:0] data;
    logic       wren;
    logic [2:0] q;

    always #5 clock = ~clock;

    ram32x3_bist #(
        .ADDR_W (5),
        .DATA_W (3),
        .RD_LAT (2)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_addr (first_fail_addr),
        .address         (address),
        .data            (data),
        .wren            (wren),
        .q               (q)
    );

    // RAM model: 0 = healthy, 1 = read bit 1 stuck at 0, 2 = every read inverted
    logic [2:0] mem [32];
    logic [4:0] ram_addr_r;
    logic       ram_we_r;
    logic [2:0] ram_d_r;
    logic [2:0] q_raw;
    int         fault_mode = 0;

    always @(posedge clock) begin
        ram_addr_r <= address;
        ram_we_r   <= wren;
        ram_d_r    <= data;
        if (wren) mem[address] <= data;
    end

    always_comb begin
        q_raw = ram_we_r ? ram_d_r : mem[ram_addr_r];
        case (fault_mode)
            1:       q = q_raw & 3'b101;
            2:       q = ~q_raw;
            default: q = q_raw;
        endcase
    end

`ifdef RAM32X3_BIST_INV_PASS_EN
    localparam int EXP_EDGES = 132;
    localparam int EXP_W13   = 2;
    localparam int EXP_W0    = 7;
    localparam int STUCK_ERR = 32;
    localparam int INV_ERR   = 63;
`else
    localparam int EXP_EDGES = 66;
    localparam int EXP_W13   = 5;
    localparam int EXP_W0    = 0;
    localparam int STUCK_ERR = 16;
    localparam int INV_ERR   = 32;
`endif

    typedef struct {
        int fault;
        int exp_pass;
        int exp_err;
        int exp_ffa;
    } vec_t;

    vec_t vecs [4];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Starts a test (start driven before edge e0) and returns the number of
    // edges after e0 at which done was first seen; leaves the DUT in IDLE.
    task automatic run_test(input bit hold, output int edges);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("pass_cleared", int'(pass), 0);
        check("err_cleared", int'(err_count), 0);
        edges = 0;
        while (!done && edges < 400) begin
            tick();
            edges++;
        end
        start = 1'b0;
        tick();
        check("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        int edges;
        int dcount;
        int dedge;
        int guard;

        vecs[0] = '{fault: 0, exp_pass: 1, exp_err: 0,         exp_ffa: 0};
        vecs[1] = '{fault: 1, exp_pass: 0, exp_err: STUCK_ERR, exp_ffa: 2};
        vecs[2] = '{fault: 2, exp_pass: 0, exp_err: INV_ERR,   exp_ffa: 0};
        vecs[3] = '{fault: 0, exp_pass: 1, exp_err: 0,         exp_ffa: 0};

        // Reset state
        reset_n = 1'b0;
        start   = 1'b0;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_ffa", int'(first_fail_addr), 0);
        check("rst_address", int'(address), 0);
        check("rst_data", int'(data), 0);
        check("rst_wren", int'(wren), 0);
        reset_n = 1'b1;
        tick();
        check("idle_wren", int'(wren), 0);

        // Table-driven full runs
        for (int i = 0; i < 4; i++) begin
            fault_mode = vecs[i].fault;
            run_test(1'b0, edges);
            check("done_edge", edges, EXP_EDGES);
            check("pass", int'(pass), vecs[i].exp_pass);
            check("err_count", int'(err_count), vecs[i].exp_err);
            check("first_fail_addr", int'(first_fail_addr), vecs[i].exp_ffa);
            check("busy_idle", int'(busy), 0);
            check("word13", int'(mem[13]), EXP_W13);
            check("word0", int'(mem[0]), EXP_W0);
            $display("vector %0d fault=%0d edges=%0d pass=%0d err=%0d ffa=%0d",
                     i, fault_mode, edges, pass, err_count, first_fail_addr);
        end
        fault_mode = 0;

        // start held high throughout: one done, then restart from IDLE
        start = 1'b1;
        tick();
        dcount = 0;
        dedge  = 0;
        for (int k = 1; k <= EXP_EDGES + 1; k++) begin
            tick();
            if (done) begin
                dcount++;
                if (dedge == 0) dedge = k;
            end
        end
        check("held_done_count", dcount, 1);
        check("held_done_edge", dedge, EXP_EDGES);
        check("held_busy_idle", int'(busy), 0);
        tick();
        check("held_restart_busy", int'(busy), 1);
        start = 1'b0;
        guard = 0;
        while (!done && guard < 400) begin
            tick();
            guard++;
        end
        check("held_restart_done", int'(done), 1);
        check("held_restart_pass", int'(pass), 1);
        tick();
        $display("held-start sequence dones=%0d edge=%0d", dcount, dedge);

        // Extra start pulse during READ is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        dcount = 0;
        dedge  = 0;
        for (int k = 1; k <= EXP_EDGES + 4; k++) begin
            tick();
            if (k == 40) start = 1'b1;
            if (k == 41) start = 1'b0;
            if (done) begin
                dcount++;
                if (dedge == 0) dedge = k;
            end
        end
        check("midread_done_count", dcount, 1);
        check("midread_done_edge", dedge, EXP_EDGES);
        check("midread_no_restart", int'(busy), 0);
        $display("mid-read pulse sequence dones=%0d edge=%0d", dcount, dedge);

        // Asynchronous reset in the middle of WRITE
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (address != 5'd10 && guard < 100) begin
            tick();
            guard++;
        end
        check("abort_reached_addr10", int'(address), 10);
        check("abort_wren_before", int'(wren), 1);
        reset_n = 1'b0;
        #1;
        check("abort_wren", int'(wren), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_address", int'(address), 0);
        check("abort_data", int'(data), 0);
        check("abort_err", int'(err_count), 0);
        check("abort_done", int'(done), 0);
        tick();
        reset_n = 1'b1;
        tick();
        run_test(1'b0, edges);
        check("abort_rerun_edge", edges, EXP_EDGES);
        check("abort_rerun_pass", int'(pass), 1);
        check("abort_rerun_err", int'(err_count), 0);
        $display("reset-abort sequence rerun edges=%0d pass=%0d", edges, pass);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
